core_output_ctrl: RTL and testbench
===================================

CORE_OUTPUT_CTRL -- requirements
Module: core_output_ctrl

Interface
REQ-001 Parameter ROWS, default 8, PE array dimension; it sets the column count and the output row width.
REQ-002 Parameter OUTWIDTH, default 32, partial-sum width in bits (signed, two's complement).
REQ-003 Parameter DEPTH, default 8, per-column deskew FIFO depth; it SHALL be a power of two and at least 2.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rstn  input  1  reset, synchronous and active-low.
REQ-006 start  input  1  single-cycle pulse that begins a job.
REQ-007 nrows  input  16  number of output rows in the job; sampled only when start is accepted.
REQ-008 psum  input  OUTWIDTH x ROWS (unpacked [0:ROWS-1])  column results from the bottom edge of the PE array.
REQ-009 psum_valid  input  ROWS (unpacked)  per-column qualifier for psum.
REQ-010 stall  output  1  tells the array to hold; high when any column FIFO holds at least DEPTH-1 entries.
REQ-011 dout  output  OUTWIDTH x ROWS (unpacked)  one deskewed output row.
REQ-012 dout_valid  output  1  dout holds a valid row.
REQ-013 dout_ready  input  1  consumer accepts the row.
REQ-014 busy  output  1  high while the FSM is in RUN.
REQ-015 done  output  1  single-cycle pulse when the last row is accepted.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 IDLE->RUN SHALL occur on start with nrows!=0; the row counter is cleared and nrows is latched.
REQ-018 start with nrows==0 SHALL go IDLE->DONE directly, pulsing done for one cycle with no output.
REQ-019 start SHALL be ignored in RUN and DONE.
REQ-020 DONE->IDLE SHALL occur unconditionally on the next cycle.
REQ-021 In RUN, the value in column j SHALL be pushed into FIFO j on every cycle psum_valid[j]=1.
REQ-022 In IDLE, psum_valid SHALL be ignored.
REQ-023 Columns arrive skewed: column j of row r arrives j cycles after column 0. The block SHALL NOT depend on exact skew; alignment comes only from FIFO occupancy.
REQ-024 dout_valid SHALL be high exactly when the state is RUN and all ROWS FIFOs are non-empty.
REQ-025 dout[j] SHALL be the head of FIFO j, presented first-word-fall-through (no added latency).
REQ-026 Latency: a row whose last column is pushed in cycle t SHALL show dout_valid in cycle t+1.
REQ-027 On dout_valid & dout_ready, all FIFOs SHALL pop together and the row counter SHALL increment.
REQ-028 When the row counter reaches the latched nrows, the FSM SHALL go to DONE in the same handshake cycle.
REQ-029 dout and dout_valid SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-030 Simultaneous push and pop on a FIFO SHALL leave its occupancy unchanged and be legal even when full.
REQ-031 A push to a full FIFO with no pop SHALL be dropped, and the sticky internal flag ovf SHALL be set; ovf is cleared only by reset.
REQ-032 stall SHALL be computed from registered occupancy only, with no combinational path from inputs.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH, using an extra bit to tell full from empty.

Reset
REQ-034 With rstn=0 at a clock edge: state=IDLE, all FIFOs empty, row counter=0, ovf=0.
REQ-035 Reset outputs: stall=0, dout_valid=0, busy=0, done=0, dout=0.
REQ-036 Reset asserted mid-job SHALL discard all buffered data with no done pulse.

Configuration
REQ-037 Macro CORE_OUTPUT_CTRL_RELU_EN SHALL control output rectification.
REQ-038 With the macro defined, each dout[j] SHALL be 0 when the FIFO head is negative and the head otherwise; the function is combinational and adds no latency.
REQ-039 With the macro undefined, dout[j] SHALL equal the FIFO head unchanged.

Structure
REQ-040 Shared package core_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the row-counter width constant of 16.
REQ-041 Sub-module OUTBUF SHALL be one parameterised FWFT FIFO (WIDTH, DEPTH) with push, pop, din, dout, empty, full and count ports, instantiated ROWS times in a generate loop.

Verification
REQ-042 Zero-skew row: ROWS=4, nrows=1, all columns valid in one cycle with values 1,2,3,4 -> next cycle dout=1,2,3,4 and dout_valid=1; with ready=1, done pulses in that handshake cycle and busy falls.
REQ-043 Skewed rows: nrows=3, column j valid at cycles r+j -> exactly 3 rows out, in order, values intact.
REQ-044 Backpressure: dout_ready=0 for 20 cycles while pushing -> stall=1 once any count reaches DEPTH-1; after ready returns there is no loss, ovf=0, and dout is held stable throughout.
REQ-045 Overflow: push DEPTH+1 entries into column 0 with ready=0 -> ovf=1, the first DEPTH values are retained and the last is dropped.
REQ-046 Reset mid-job after 2 of 4 rows -> all outputs return to reset values, and the next job with nrows=1 behaves as in REQ-042.
REQ-047 With CORE_OUTPUT_CTRL_RELU_EN defined, input -5 -> dout 0 and input 7 -> dout 7; without the macro, -5 passes through unchanged.

Source files
------------

// File: rtl/core_pkg.sv
// Shared FSM state encoding and row-counter width for the output controller.
package core_pkg;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/outbuf.sv
// Purpose: per-column first-word-fall-through FIFO; the head is visible while non-empty and reads 0 when empty.
// Latency: a push is visible at dout on the cycle after it is written.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module outbuf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  // The pointer MSB is a wrap marker: equal low bits with differing MSBs means full.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count   = wr_q - rd_q;
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (do_push) begin
      wr_d = wr_q + (AW+1)'(1);
      mem_d[wr_q[AW-1:0]] = din;
    end
    if (do_pop) begin
      rd_d = rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/core_output_ctrl.sv
// Purpose: deskews PE-array column results into whole rows via per-column FIFOs; CORE_OUTPUT_CTRL_RELU_EN adds ReLU on dout.
// Latency: a row is presented the cycle after its last column is pushed.
// Backpressure: dout_valid/dout_ready handshake; stall asks the array to hold once any FIFO reaches DEPTH-1.
module core_output_ctrl
  import core_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int OUTWIDTH = 32,
  parameter int DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [CNT_W-1:0]           nrows,
  input  logic signed [OUTWIDTH-1:0] psum       [0:ROWS-1],
  input  logic                       psum_valid [0:ROWS-1],
  output logic                       stall,
  output logic signed [OUTWIDTH-1:0] dout       [0:ROWS-1],
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       busy,
  output logic                       done
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, nrows_q, nrows_d, cnt_inc;
  logic              ovf_q, ovf_d;
  logic              run, pop;
  logic [ROWS-1:0]   push, empty, full;
  logic [OUTWIDTH-1:0] head  [ROWS];
  logic [CW-1:0]       count [ROWS];

  assign run        = (state_q == RUN);
  assign dout_valid = run && (empty == '0);
  assign pop        = dout_valid && dout_ready;
  assign busy       = run;
  assign done       = (state_q == DONE);
  assign cnt_inc    = cnt_q + CNT_W'(1);

  for (genvar j = 0; j < ROWS; j++) begin : g_col
    assign push[j] = run && psum_valid[j];

    outbuf #(
      .WIDTH (OUTWIDTH),
      .DEPTH (DEPTH)
    ) u_buf (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push[j]),
      .pop   (pop),
      .din   (psum[j]),
      .dout  (head[j]),
      .empty (empty[j]),
      .full  (full[j]),
      .count (count[j])
    );

`ifdef CORE_OUTPUT_CTRL_RELU_EN
    assign dout[j] = head[j][OUTWIDTH-1] ? '0 : head[j];
`else
    assign dout[j] = head[j];
`endif
  end

  // Occupancy is registered inside each FIFO, so stall has no path from inputs.
  always_comb begin
    stall = 1'b0;
    for (int j = 0; j < ROWS; j++) begin
      if (count[j] >= STALL_LVL) stall = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nrows_d = nrows_q;
    ovf_d   = ovf_q || ((|(push & full)) && !pop);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (nrows != '0) begin
            state_d = RUN;
            cnt_d   = '0;
            nrows_d = nrows;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (pop) begin
          cnt_d = cnt_inc;
          if (cnt_inc == nrows_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nrows_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nrows_q <= nrows_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_core_output_ctrl.sv
// Directed bench for core_output_ctrl with ROWS=4, DEPTH=4.
module tb_core_output_ctrl;
  localparam int ROWS  = 4;
  localparam int OW    = 32;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rstn, start, dout_ready;
  logic [15:0]          nrows;
  logic signed [OW-1:0] psum       [0:ROWS-1];
  logic                 psum_valid [0:ROWS-1];
  logic signed [OW-1:0] dout       [0:ROWS-1];
  logic                 stall, dout_valid, busy, done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  core_output_ctrl #(
    .ROWS     (ROWS),
    .OUTWIDTH (OW),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .nrows      (nrows),
    .psum       (psum),
    .psum_valid (psum_valid),
    .stall      (stall),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    for (int j = 0; j < ROWS; j++) begin
      psum_valid[j] = 1'b0;
      psum[j]       = '0;
    end
  endtask

  task automatic drive_row(input int base);
    for (int j = 0; j < ROWS; j++) begin
      psum_valid[j] = 1'b1;
      psum[j]       = base + j;
    end
  endtask

  task automatic start_job(input int n);
    nrows = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic zero_skew(input string pfx);
    start_job(1);
    chk({pfx, "_busy"}, busy, 1);
    chk({pfx, "_dv_empty"}, dout_valid, 0);
    drive_row(1);
    tick();
    idle_in();
    chk({pfx, "_dv"}, dout_valid, 1);
    for (int j = 0; j < ROWS; j++) chk($sformatf("%s_dout%0d", pfx, j), dout[j], j + 1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk({pfx, "_done"}, done, 1);
    chk({pfx, "_busy_fall"}, busy, 0);
    tick();
    chk({pfx, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int rcv, first_v, pushed, held_bad;
    bit saw_done;
    logic signed [OW-1:0] exp_v;

    rstn = 1'b0; start = 1'b0; nrows = '0; dout_ready = 1'b0;
    idle_in();
    tick(); tick();
    chk("rst_stall", stall, 0);
    chk("rst_dv", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout0", dout[0], 0);
    chk("rst_ovf", dut.ovf_q, 0);
    rstn = 1'b1;
    tick();

    zero_skew("zs");

    // Zero-row job goes straight to DONE.
    start_job(0);
    chk("z0_done", done, 1);
    chk("z0_busy", busy, 0);
    chk("z0_dv", dout_valid, 0);
    tick();
    chk("z0_done_pulse", done, 0);

    // Skewed columns: column j of row r arrives at cycle r+j.
    start_job(3);
    dout_ready = 1'b1;
    rcv = 0; first_v = -1; saw_done = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (dout_valid) begin
        if (first_v < 0) first_v = c;
        for (int j = 0; j < ROWS; j++)
          chk($sformatf("skew_r%0d_c%0d", rcv, j), dout[j], rcv * 10 + j + 1);
        rcv++;
      end
      if (done) saw_done = 1'b1;
      for (int j = 0; j < ROWS; j++) begin
        if (c - j >= 0 && c - j < 3) begin
          psum_valid[j] = 1'b1;
          psum[j]       = (c - j) * 10 + j + 1;
        end else begin
          psum_valid[j] = 1'b0;
          psum[j]       = '0;
        end
      end
      tick();
    end
    idle_in();
    dout_ready = 1'b0;
    chk("skew_first_valid", first_v, 4);
    chk("skew_rows", rcv, 3);
    chk("skew_done", saw_done, 1);

    // Backpressure: consumer stalls 20 cycles while the array honours stall.
    start_job(6);
    pushed = 0; held_bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (dout_valid && (dout[0] != 50 || dout[3] != 53)) held_bad++;
      if (c > 0 && !dout_valid) held_bad++;
      if (!stall && pushed < 6) begin
        drive_row(50 + pushed * 4);
        pushed++;
      end else begin
        idle_in();
      end
      tick();
    end
    idle_in();
    chk("bp_held", held_bad, 0);
    chk("bp_stall", stall, 1);
    chk("bp_pushed", pushed, 3);
    dout_ready = 1'b1;
    rcv = 0; saw_done = 1'b0;
    for (int c = 0; c < 40 && !saw_done; c++) begin
      if (dout_valid) begin
        for (int j = 0; j < ROWS; j++)
          chk($sformatf("bp_r%0d_c%0d", rcv, j), dout[j], 50 + rcv * 4 + j);
        rcv++;
      end
      if (done) saw_done = 1'b1;
      if (!stall && pushed < 6) begin
        drive_row(50 + pushed * 4);
        pushed++;
      end else begin
        idle_in();
      end
      tick();
    end
    idle_in();
    dout_ready = 1'b0;
    chk("bp_rows", rcv, 6);
    chk("bp_done", saw_done, 1);
    chk("bp_ovf", dut.ovf_q, 0);
    tick();

    // Rectification (or pass-through in the default build).
    start_job(1);
    for (int j = 0; j < ROWS; j++) begin
      psum_valid[j] = 1'b1;
      psum[j]       = (j % 2 == 0) ? -5 : 7;
    end
    tick();
    idle_in();
`ifdef CORE_OUTPUT_CTRL_RELU_EN
    exp_v = 0;
`else
    exp_v = -5;
`endif
    chk("relu_neg", dout[0], exp_v);
    chk("relu_pos", dout[1], 7);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("relu_done", done, 1);
    tick();

    // Overflow: DEPTH+1 pushes into column 0; the last one must be dropped.
    start_job(5);
    for (int k = 0; k < DEPTH + 1; k++) begin
      psum_valid[0] = 1'b1;
      psum[0]       = 100 + k;
      tick();
    end
    idle_in();
    chk("ovf_flag", dut.ovf_q, 1);
    chk("ovf_count0", dut.g_col[0].u_buf.count, DEPTH);
    chk("ovf_dv", dout_valid, 0);
    for (int k = 0; k < DEPTH; k++) begin
      for (int j = 1; j < ROWS; j++) begin
        psum_valid[j] = 1'b1;
        psum[j]       = 0;
      end
      tick();
      idle_in();
      chk($sformatf("ovf_dv_%0d", k), dout_valid, 1);
      chk($sformatf("ovf_keep_%0d", k), dout[0], 100 + k);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
    end
    drive_row(200);
    tick();
    idle_in();
    chk("ovf_dropped", dout[0], 200);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("ovf_done", done, 1);
    tick();

    // Reset mid-job after two of four rows.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("rst2_ovf_clr", dut.ovf_q, 0);
    start_job(4);
    for (int r = 0; r < 3; r++) begin
      drive_row(10 * r);
      tick();
    end
    idle_in();
    dout_ready = 1'b1;
    tick(); tick();
    dout_ready = 1'b0;
    chk("mid_cnt", dut.cnt_q, 2);
    chk("mid_busy", busy, 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mid_stall", stall, 0);
    chk("mid_dv", dout_valid, 0);
    chk("mid_busy_rst", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_dout0", dout[0], 0);
    chk("mid_cnt_rst", dut.cnt_q, 0);
    tick();
    chk("mid_no_done", done, 0);
    zero_skew("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
